// File: rtl/gf180mcu_fd_sc_mcu7t5v0__setn_seq.sv
// Staggered active-low SETN sequencer: asynchronous assertion from RN/REQ_N,
// synchronized release, minimum hold, then group-by-group release spaced by GAP.
module gf180mcu_fd_sc_mcu7t5v0__setn_seq #(
    parameter int STAGES = 2,   // release synchronizer depth (2..4)
    parameter int HOLD   = 4,   // cycles SETN stays low after synchronized release (1..255)
    parameter int GROUPS = 4,   // staggered SETN outputs (1..8)
    parameter int GAP    = 2    // cycles between consecutive group releases (1..15)
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              REQ_N,
    output logic [GROUPS-1:0] SETN,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_STAGGER = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);
    localparam logic [2:0] IDX_LAST  = 3'(GROUPS - 1);

    logic              clr_n;
    logic [STAGES-1:0] sync;
    logic              sync_pre;
    logic              sync_rel;
    state_t            state;
    logic [7:0]        hold_cnt;
    logic [3:0]        gap_cnt;
    logic [2:0]        idx;

    // NOTE: clr_n is the only async clear for every flop below; it asserts
    // instantly and releases only through the synchronizer chain.
    assign clr_n = RN & REQ_N;

    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], 1'b1};
        end
    end

    assign sync_pre = sync[STAGES-2];
    assign sync_rel = sync[STAGES-1];

    // HOLD is entered on the same edge that sync_rel rises, so the first
    // group releases exactly STAGES + HOLD edges after clr_n rises.
    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            state    <= ST_ASSERT;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            SETN     <= '0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    if (sync_pre) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (sync_rel) begin
                        if (hold_cnt == HOLD_LAST) begin
                            SETN[0] <= 1'b1;
                            if (IDX_LAST == 3'd0) begin
                                state <= ST_RUN;
                                DONE  <= 1'b1;
                            end else begin
                                state   <= ST_STAGGER;
                                idx     <= 3'd1;
                                gap_cnt <= GAP_LAST;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                ST_STAGGER: begin
                    if (gap_cnt == 4'd0) begin
                        SETN <= SETN | (GROUPS'(1) << idx);
                        if (idx == IDX_LAST) begin
                            state <= ST_RUN;
                            DONE  <= 1'b1;
                        end else begin
                            idx     <= idx + 3'd1;
                            gap_cnt <= GAP_LAST;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign BUSY = ~&SETN;

endmodule
